// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache refill path: state encoding, widths,
// the never-written fill value and the latency counter width helper.
package cache_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam int          ADDR_W_DEF    = 6;
    localparam int          MEM_LAT_DEF   = 4;
    localparam logic [31:0] INIT_WORD_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // The counter must reach MEM_LAT-1; sized as $clog2(MEM_LAT+1), never below one bit.
    function automatic int lat_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/cache_refill_unit_if.sv
// Request/response bundle between the cache controller (master) and the refill unit (slave).
interface cache_refill_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wb;
    logic [ADDR_W-1:0] req_wb_addr;
    logic [DATA_W-1:0] req_wb_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              busy;

    modport master (
        output req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/cache_backing_store.sv
// Modelled main memory: word array plus per-word "written" bitmap. Reads are
// combinational and return INIT_WORD for words never written since reset.
module cache_backing_store
    import cache_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] INIT_WORD = INIT_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_written;

    // Array contents survive reset; only the bitmap is cleared.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bitmap
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_written[gi] <= 1'b0;
            end else if (i_wr_en && (i_wr_addr == ADDR_W'(gi))) begin
                r_written[gi] <= 1'b1;
            end
        end
    end

    assign o_rd_data = r_written[i_rd_addr] ? r_mem[i_rd_addr] : INIT_WORD;

endmodule

// File: rtl/cache_refill_unit.sv
// Cache miss refill unit: optional dirty-victim write-back, fixed-latency fill read,
// held response. Define REFILL_STATS_EN to add saturating fill/write-back counters.
module cache_refill_unit
    import cache_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                MEM_LAT   = MEM_LAT_DEF,
    parameter logic [DATA_W-1:0] INIT_WORD = INIT_WORD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    cache_refill_unit_if.slave  bus
`ifdef REFILL_STATS_EN
    ,
    output logic [15:0]         fill_cnt,
    output logic [15:0]         wb_cnt
`endif
);
    localparam int               LAT_W    = lat_cnt_w(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    state_t            r_state, w_state_next;
    logic [LAT_W-1:0]  r_lat, w_lat_next;
    logic [ADDR_W-1:0] r_addr, r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_resp_valid, w_resp_valid_next;
    logic [DATA_W-1:0] r_resp_data, w_resp_data_next;
    logic              w_capture, w_wr_en, w_lat_done, w_resp_hs;
    logic [DATA_W-1:0] w_rd_data;

    cache_backing_store #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_WORD (INIT_WORD)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wb_addr),
        .i_wr_data (r_wb_data),
        .i_rd_addr (r_addr),
        .o_rd_data (w_rd_data)
    );

    assign w_lat_done = (r_lat == LAT_LAST);
    assign w_resp_hs  = (r_state == ST_RESP) && bus.resp_ready;

    always_comb begin
        w_state_next      = r_state;
        w_lat_next        = r_lat;
        w_resp_valid_next = r_resp_valid;
        w_resp_data_next  = r_resp_data;
        w_capture         = 1'b0;
        w_wr_en           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_capture    = 1'b1;
                    w_lat_next   = '0;
                    w_state_next = bus.req_wb ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                if (w_lat_done) begin
                    w_wr_en      = 1'b1;
                    w_lat_next   = '0;
                    w_state_next = ST_FILL;
                end else begin
                    w_lat_next = r_lat + 1'b1;
                end
            end
            ST_FILL: begin
                // The write-back committed on an earlier edge, so a same-address fill sees it.
                if (w_lat_done) begin
                    w_resp_data_next  = w_rd_data;
                    w_resp_valid_next = 1'b1;
                    w_lat_next        = '0;
                    w_state_next      = ST_RESP;
                end else begin
                    w_lat_next = r_lat + 1'b1;
                end
            end
            ST_RESP: begin
                if (w_resp_hs) begin
                    w_resp_valid_next = 1'b0;
                    w_state_next      = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lat        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_addr       <= '0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_lat        <= w_lat_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_data  <= w_resp_data_next;
            if (w_capture) begin
                r_addr    <= bus.req_addr;
                r_wb_addr <= bus.req_wb_addr;
                r_wb_data <= bus.req_wb_data;
            end
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;

`ifdef REFILL_STATS_EN
    logic [15:0] r_fill_cnt, r_wb_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (w_resp_hs && (r_fill_cnt != 16'hFFFF)) begin
                r_fill_cnt <= r_fill_cnt + 16'd1;
            end
            if (w_wr_en && (r_wb_cnt != 16'hFFFF)) begin
                r_wb_cnt <= r_wb_cnt + 16'd1;
            end
        end
    end

    assign fill_cnt = r_fill_cnt;
    assign wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_cache_refill_unit.sv
// Scoreboard bench for cache_refill_unit: a driver issues directed then random
// refill requests against a word-level memory model; a monitor checks every response.
module tb_cache_refill_unit;
    localparam int          MEM_LAT = 4;
    localparam logic [31:0] INIT    = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    cache_refill_unit_if #(.DATA_W(32), .ADDR_W(6)) bus_if ();

`ifdef REFILL_STATS_EN
    logic [15:0] fill_cnt, wb_cnt;
`endif

    cache_refill_unit #(
        .DATA_W    (32),
        .ADDR_W    (6),
        .MEM_LAT   (MEM_LAT),
        .INIT_WORD (INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if)
`ifdef REFILL_STATS_EN
        ,
        .fill_cnt (fill_cnt),
        .wb_cnt   (wb_cnt)
`endif
    );

    // Reference model: memory words, written flags, expected responses.
    logic [31:0] mem_m [64];
    bit          wr_m  [64];
    exp_t        sb    [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;
    int          fill_exp = 0;
    int          wb_exp = 0;
    int          rr_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // resp_ready: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus_if.resp_ready = 1'b1;
            1:       bus_if.resp_ready = ($urandom_range(0, 99) < 60);
            default: bus_if.resp_ready = 1'b0;
        endcase
    end

    task automatic drive_req(input logic [5:0] a, input logic wb, input logic [5:0] wba,
                             input logic [31:0] wbd);
        @(posedge clk);
        #1;
        bus_if.req_valid   = 1'b1;
        bus_if.req_addr    = a;
        bus_if.req_wb      = wb;
        bus_if.req_wb_addr = wba;
        bus_if.req_wb_data = wbd;
    endtask

    task automatic await_accept();
        exp_t e;
        bit   done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (bus_if.req_ready) begin
                if (bus_if.req_wb) begin
                    mem_m[bus_if.req_wb_addr] = bus_if.req_wb_data;
                    wr_m[bus_if.req_wb_addr]  = 1'b1;
                    wb_exp++;
                end
                e.data = wr_m[bus_if.req_addr] ? mem_m[bus_if.req_addr] : INIT;
                e.lat  = bus_if.req_wb ? 2 * MEM_LAT : MEM_LAT;
                e.acc  = cyc + 1;
                sb.push_back(e);
                done = 1;
            end
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        // Changing the request after acceptance must have no effect.
        bus_if.req_valid   = 1'b0;
        bus_if.req_addr    = 6'($urandom);
        bus_if.req_wb      = 1'($urandom);
        bus_if.req_wb_addr = 6'($urandom);
        bus_if.req_wb_data = $urandom;
    endtask

    task automatic send_req(input logic [5:0] a, input logic wb, input logic [5:0] wba,
                            input logic [31:0] wbd);
        drive_req(a, wb, wba, wbd);
        await_accept();
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus_if.resp_valid && bus_if.req_ready) done = 1;
        end
        if (!done) check("idle_timeout", 64'd0, 64'd1);
    endtask

    // Monitor
    bit          prev_valid = 0;
    bit          hs_pending = 0;
    logic [31:0] held_data  = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 0;
            hs_pending = 0;
        end else begin
            if (hs_pending) begin
                check("req_ready_after_hs", 64'(bus_if.req_ready), 64'd1);
                check("resp_valid_after_hs", 64'(bus_if.resp_valid), 64'd0);
            end
            if (bus_if.resp_valid) begin
                check("req_ready_in_resp", 64'(bus_if.req_ready), 64'd0);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 64'(bus_if.resp_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        n_txn++;
                        $display("txn %0d: resp_data=%h expected=%h latency=%0d expected=%0d",
                                 n_txn, bus_if.resp_data, e.data, cyc - e.acc, e.lat);
                        check("resp_data", 64'(bus_if.resp_data), 64'(e.data));
                        check("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                    held_data = bus_if.resp_data;
                end else begin
                    check("resp_data_stable", 64'(bus_if.resp_data), 64'(held_data));
                end
            end
            hs_pending = bus_if.resp_valid && bus_if.resp_ready;
            if (hs_pending) fill_exp++;
            prev_valid = bus_if.resp_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        bus_if.req_valid   = 1'b0;
        bus_if.req_addr    = '0;
        bus_if.req_wb      = 1'b0;
        bus_if.req_wb_addr = '0;
        bus_if.req_wb_data = '0;
        bus_if.resp_ready  = 1'b0;
        for (int i = 0; i < 64; i++) wr_m[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(bus_if.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus_if.resp_valid), 64'd0);
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_resp_data", 64'(bus_if.resp_data), 64'd0);

        // Cold fill, write-back then hit on the same word, untouched neighbour
        send_req(6'h05, 1'b0, 6'h00, 32'h0);
        wait_idle();
        send_req(6'h05, 1'b1, 6'h05, 32'hCAFEBABE);
        wait_idle();
        send_req(6'h05, 1'b0, 6'h00, 32'h0);
        send_req(6'h06, 1'b0, 6'h00, 32'h0);
        wait_idle();

        // Stall in RESP while a new request waits
        rr_mode = 2;
        send_req(6'h07, 1'b1, 6'h09, 32'h0BADF00D);
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus_if.resp_valid) got = 1;
        end
        if (!got) check("stall_resp_timeout", 64'd0, 64'd1);
        drive_req(6'h09, 1'b0, 6'h00, 32'h0);
        repeat (5) begin
            @(negedge clk);
            check("stall_req_ready", 64'(bus_if.req_ready), 64'd0);
            check("stall_busy", 64'(bus_if.busy), 64'd1);
        end
        rr_mode = 0;
        await_accept();
        wait_idle();

        // Reset in the second write-back cycle
        send_req(6'h03, 1'b1, 6'h2A, 32'h12345678);
        @(negedge clk);
        check("wb_busy", 64'(bus_if.busy), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 64'(bus_if.req_ready), 64'd1);
        check("midrst_resp_valid", 64'(bus_if.resp_valid), 64'd0);
        check("midrst_busy", 64'(bus_if.busy), 64'd0);
        check("midrst_resp_data", 64'(bus_if.resp_data), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 64; i++) wr_m[i] = 1'b0;
        fill_exp = 0;
        wb_exp   = 0;
        send_req(6'h2A, 1'b0, 6'h00, 32'h0);
        send_req(6'h05, 1'b0, 6'h00, 32'h0);
        wait_idle();

        // Random traffic over a small address window to force reuse
        rr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            send_req(6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     6'($urandom_range(0, 15)), $urandom);
        end
        wait_idle();
        rr_mode = 0;

`ifdef REFILL_STATS_EN
        @(negedge clk);
        check("fill_cnt", 64'(fill_cnt), 64'(fill_exp > 65535 ? 65535 : fill_exp));
        check("wb_cnt", 64'(wb_cnt), 64'(wb_exp > 65535 ? 65535 : wb_exp));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
